rf_write_arbiter: RTL and testbench

//   Shares the single register-file write port between NUM_REQ writeback sources,
//   e.g. the ALU, load unit and multiply/divide unit.
//   - One winner per cycle, picked by round-robin arbitration.
//   - The winner's address/data are registered and driven to the write port.
//   - wr_addr feeds the 5-to-32 write-enable decoder.
//   - Sits between the writeback sources and the register file.

---
 rtl/rf_write_arbiter.sv | 98 +++++++++
 tb/tb_rf_write_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among
// NUM_REQ writeback sources, with a registered write stage.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   stall                 blocks new grants this cycle
//   req_valid/addr/data   packed requester bundles, slice i = requester i
//   req_ready             one-hot grant (transfer = valid & ready)
//   wr_en/addr/data/src   registered write port, one cycle after transfer
//   conflict_cnt          saturating count of cycles with >1 valid request
module rf_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 32,
    parameter int SELECTOR = 5,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*SELECTOR-1:0]  req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         wr_en,
    output logic [SELECTOR-1:0]          wr_addr,
    output logic [WIDTH-1:0]             wr_data,
    output logic [IW-1:0]                wr_src,
    output logic [15:0]                  conflict_cnt
);

    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       gidx;
    logic [IW-1:0]       scan;
    logic                found;
    logic                xfer;
    logic                conflict;
    logic                wr_en_q;
    logic [NUM_REQ-1:0]  grant;
    logic [SELECTOR-1:0] gaddr;
    logic [WIDTH-1:0]    gdata;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req_valid[scan]) begin
                found = 1'b1;
                gidx  = scan;
            end
        end
    end

    assign xfer = found & ~stall & ~reset;

    always_comb begin
        grant = '0;
        if (xfer)
            grant[gidx] = 1'b1;
    end

    assign req_ready = grant;
    assign gaddr     = req_addr[int'(gidx)*SELECTOR +: SELECTOR];
    assign gdata     = req_data[int'(gidx)*WIDTH +: WIDTH];
    assign conflict  = $countones(req_valid) > 1;

    // A registered write is discarded as soon as reset is seen.
    assign wr_en = wr_en_q & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            wr_src       <= '0;
            rr_ptr       <= '0;
            conflict_cnt <= '0;
        end else begin
            if (xfer) begin
                // Writes to register 0 complete the handshake but never
                // reach the register file.
                wr_en_q <= (gaddr != '0);
                wr_addr <= gaddr;
                wr_data <= gdata;
                wr_src  <= gidx;
                rr_ptr  <= (gidx == IW'(NUM_REQ - 1)) ? '0
                                                      : gidx + IW'(1);
            end else begin
                wr_en_q <= 1'b0;
            end
            if (conflict && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus
// randomized traffic against a behavioural round-robin model.
module tb_rf_write_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int S = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic [N-1:0]    req_valid;
    logic [N*S-1:0]  req_addr;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [S-1:0]    wr_addr;
    logic [W-1:0]    wr_data;
    logic [1:0]      wr_src;
    logic [15:0]     conflict_cnt;

    int compared = 0;
    int mismatched = 0;

    // behavioural model state
    int       m_ptr = 0;
    bit       m_en = 0;
    bit [4:0] m_addr = 0;
    bit [31:0] m_data = 0;
    int       m_src = 0;
    int       m_cnt = 0;

    rf_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .SELECTOR(S)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_src(wr_src), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic int winner();
        if (reset || stall) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        int g = winner();
        logic [N-1:0] r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic void model_edge();
        int g = winner();
        int nv = 0;
        if (reset) begin
            m_en = 0; m_addr = 0; m_data = 0; m_src = 0;
            m_ptr = 0; m_cnt = 0;
            return;
        end
        if (g >= 0) begin
            m_addr = req_addr[g*S +: S];
            m_data = req_data[g*W +: W];
            m_src  = g;
            m_en   = (m_addr != 0);
            m_ptr  = (g + 1) % N;
        end else begin
            m_en = 0;
        end
        for (int i = 0; i < N; i++) nv += int'(req_valid[i]);
        if (nv >= 2 && m_cnt < 65535) m_cnt++;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_req(input int i, input logic [S-1:0] a,
                           input logic [W-1:0] d);
        req_valid[i] = 1'b1;
        req_addr[i*S +: S] = a;
        req_data[i*W +: W] = d;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; req_valid = '1;
        req_addr = '1; req_data = '1;
        #1;
        compared++;
        if (req_ready !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            compared++;
            if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0) begin
                mismatched++;
                $display("FAIL reset_wr got en=%b a=%h d=%h want 0/0/0",
                         wr_en, wr_addr, wr_data);
            end
            compared++;
            if (conflict_cnt !== 16'd0 || req_ready !== 4'b0) begin
                mismatched++;
                $display("FAIL reset_cnt got cnt=%0d rdy=%b want 0/0000",
                         conflict_cnt, req_ready);
            end
        end
    endtask

    task automatic test_single();
        reset = 0; req_valid = '0; req_addr = '0; req_data = '0;
        set_req(0, 5'd9, 32'hDEADBEEF);
        #1;
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++;
            $display("FAIL single_ready got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        compared++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd9 ||
            wr_data !== 32'hDEADBEEF || wr_src !== 2'd0) begin
            mismatched++;
            $display("FAIL single_wr got en=%b a=%0d d=%h s=%0d want 1/9/deadbeef/0",
                     wr_en, wr_addr, wr_data, wr_src);
        end
        tick();
        compared++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd9) begin
            mismatched++;
            $display("FAIL single_hold got en=%b a=%0d want 0/9", wr_en, wr_addr);
        end
    endtask

    task automatic test_round_robin();
        reset = 1; req_valid = '0;
        tick();
        reset = 0;
        for (int i = 0; i < N; i++)
            set_req(i, 5'(i + 1), 32'(i * 32'h1111));
        for (int c = 0; c < 8; c++) begin
            #1;
            compared++;
            if (req_ready !== (4'b0001 << (c % 4))) begin
                mismatched++;
                $display("FAIL rr_grant c=%0d got %b want %b",
                         c, req_ready, 4'b0001 << (c % 4));
            end
            tick();
            compared++;
            if (wr_en !== 1'b1 || wr_src !== 2'(c % 4) ||
                wr_addr !== 5'((c % 4) + 1)) begin
                mismatched++;
                $display("FAIL rr_write c=%0d got en=%b s=%0d a=%0d want 1/%0d/%0d",
                         c, wr_en, wr_src, wr_addr, c % 4, (c % 4) + 1);
            end
        end
        compared++;
        if (conflict_cnt !== 16'd8) begin
            mismatched++;
            $display("FAIL rr_conflict got %0d want 8", conflict_cnt);
        end
        req_valid = '0;
    endtask

    task automatic test_zero_drop();
        reset = 1;
        tick();
        reset = 0;
        set_req(2, 5'd0, 32'h1234);
        #1;
        compared++;
        if (req_ready !== 4'b0100) begin
            mismatched++;
            $display("FAIL zero_ready got %b want 0100", req_ready);
        end
        tick();
        compared++;
        if (wr_en !== 1'b0 || wr_src !== 2'd2) begin
            mismatched++;
            $display("FAIL zero_drop got en=%b s=%0d want 0/2", wr_en, wr_src);
        end
        req_valid = '1;
        #1;
        compared++;
        if (req_ready !== 4'b1000) begin
            mismatched++;
            $display("FAIL zero_ptr got %b want 1000", req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_stall();
        req_valid = '0;
        set_req(0, 5'd4, 32'hA5A5_0004);
        #1;
        tick();
        req_valid = '0;
        set_req(1, 5'd7, 32'h0BAD_F00D);
        stall = 1;
        #1;
        compared++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd4) begin
            mismatched++;
            $display("FAIL stall_pending got en=%b a=%0d want 1/4", wr_en, wr_addr);
        end
        for (int c = 0; c < 3; c++) begin
            compared++;
            if (req_ready !== 4'b0) begin
                mismatched++;
                $display("FAIL stall_ready c=%0d got %b want 0000", c, req_ready);
            end
            tick();
        end
        stall = 0;
        #1;
        compared++;
        if (req_ready !== 4'b0010 || wr_en !== 1'b0) begin
            mismatched++;
            $display("FAIL stall_release got rdy=%b en=%b want 0010/0",
                     req_ready, wr_en);
        end
        tick();
        req_valid = '0;
        compared++;
        if (wr_en !== 1'b1 || wr_src !== 2'd1 || wr_data !== 32'h0BAD_F00D) begin
            mismatched++;
            $display("FAIL stall_write got en=%b s=%0d d=%h want 1/1/0badf00d",
                     wr_en, wr_src, wr_data);
        end
    endtask

    task automatic test_reset_midop();
        req_valid = '0;
        set_req(3, 5'd17, 32'hCAFE_0017);
        #1;
        tick();
        req_valid = '0;
        reset = 1;
        #1;
        compared++;
        if (wr_en !== 1'b0) begin
            mismatched++;
            $display("FAIL midop_discard got en=%b want 0", wr_en);
        end
        tick();
        reset = 0;
        req_valid = '1;
        #1;
        compared++;
        if (req_ready !== 4'b0001 || wr_en !== 1'b0) begin
            mismatched++;
            $display("FAIL midop_restart got rdy=%b en=%b want 0001/0",
                     req_ready, wr_en);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] g;
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 5'($urandom_range(0, 31)), $urandom);
            stall = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 49) == 0);
            #1;
            g = exp_grant();
            compared++;
            if (req_ready !== g) begin
                mismatched++;
                $display("FAIL rand_ready c=%0d got %b want %b", c, req_ready, g);
            end
            tick();
            compared++;
            if (wr_en !== (m_en && !reset) || wr_addr !== m_addr ||
                wr_data !== m_data || wr_src !== 2'(m_src)) begin
                mismatched++;
                $display("FAIL rand_wr c=%0d got %b/%0d/%h/%0d want %b/%0d/%h/%0d",
                         c, wr_en, wr_addr, wr_data, wr_src,
                         m_en && !reset, m_addr, m_data, m_src);
            end
            compared++;
            if (conflict_cnt !== 16'(m_cnt)) begin
                mismatched++;
                $display("FAIL rand_cnt c=%0d got %0d want %0d", c, conflict_cnt, m_cnt);
            end
            req_valid = req_valid & ~g;
        end
        reset = 0; stall = 0; req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_drop();
        test_stall();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
